gol_matrix_scan: RTL and testbench

- Downstream display stage for the Game-of-Life top level.
- Accepts complete 8x8 board snapshots from the generation engine over a valid/ready handshake and double-buffers them.
- Time-multiplexes the active board onto an LED matrix: one-hot row select plus column data, with a blanking gap between rows to prevent ghosting.

---
 rtl/gol_matrix_scan.sv | 171 +++++++++++++++++
 tb/tb_gol_matrix_scan.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gol_matrix_scan.sv
// LED matrix scanner for the Game-of-Life display path: double-buffers 8x8 board
// snapshots and time-multiplexes the active board one row at a time with blanking gaps.
module gol_matrix_scan #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_out,
  output logic                 frame_done
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  logic [1:0]           r_state;
  logic [RW-1:0]        r_row;
  logic [CW-1:0]        r_cnt;
  logic [ROWS*COLS-1:0] r_shadow;
  logic [ROWS*COLS-1:0] r_active;
  logic                 r_shadow_full;
  logic                 r_have_frame;
  logic [ROWS-1:0]      r_row_sel;
  logic [COLS-1:0]      r_col_out;
  logic                 r_frame_done;

  logic [1:0]           w_state_nxt;
  logic [RW-1:0]        w_row_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_swap;
  logic                 w_done_nxt;
  logic                 w_accept;
  logic [ROWS*COLS-1:0] w_src;
  logic [ROWS-1:0]      w_row_sel_nxt;
  logic [COLS-1:0]      w_col_nxt;

  // Ready comes straight from the shadow flag, so frame_valid never loops back into it.
  assign frame_ready = ~r_shadow_full;
  assign w_accept    = frame_valid & ~r_shadow_full;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_swap      = 1'b0;
    w_done_nxt  = 1'b0;

    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_row_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_shadow_full) begin
            w_swap      = 1'b1;
            w_state_nxt = ST_SHOW;
            w_row_nxt   = '0;
            w_cnt_nxt   = '0;
          end else if (r_have_frame) begin
            w_state_nxt = ST_SHOW;
            w_row_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end
        ST_SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
            w_cnt_nxt   = '0;
            if (r_row == ROW_LAST) begin
              w_row_nxt  = '0;
              w_done_nxt = 1'b1;
              w_swap     = r_shadow_full;
            end else begin
              w_row_nxt = r_row + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_row_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // On a swap edge the active buffer is not yet updated, so row data comes from the shadow.
  assign w_src = w_swap ? r_shadow : r_active;

  always_comb begin
    w_row_sel_nxt = '0;
    w_col_nxt     = '0;
    if (w_state_nxt == ST_SHOW) begin
      w_row_sel_nxt = ROWS'(1) << w_row_nxt;
      w_col_nxt     = w_src[int'(w_row_nxt)*COLS +: COLS];
    end
  end

  // NOTE: the frame buffers are plain registers, so they are cleared by reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_active      <= '0;
      r_shadow_full <= 1'b0;
      r_have_frame  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (w_accept) begin
        r_shadow      <= frame_in;
        r_shadow_full <= 1'b1;
      end else if (w_swap) begin
        r_shadow_full <= 1'b0;
      end
      if (w_swap) begin
        r_active     <= r_shadow;
        r_have_frame <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_cnt        <= '0;
      r_row_sel    <= '0;
      r_col_out    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_cnt        <= w_cnt_nxt;
      r_row_sel    <= w_row_sel_nxt;
      r_col_out    <= w_col_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  assign row_sel    = r_row_sel;
  assign col_out    = r_col_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Directed bench for gol_matrix_scan: expected per-cycle display outputs are queued
// when frames are handed over and popped every clock.
module tb_gol_matrix_scan;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int DW        = 4;
  localparam int BL        = 2;
  localparam int PER       = DW + BL;
  localparam int FRAME_LEN = ROWS * PER;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 enable = 1'b0;
  logic [ROWS*COLS-1:0] frame_in = '0;
  logic                 frame_valid = 1'b0;
  logic                 frame_ready;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      col_out;
  logic                 frame_done;

  always #5 clk = ~clk;

  gol_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .DWELL(DW), .BLANK(BL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .row_sel     (row_sel),
    .col_out     (col_out),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [7:0] rs;
    logic [7:0] co;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  localparam logic [63:0] FRAME_A = 64'h8040201008040201;
  localparam logic [63:0] FRAME_B = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] FRAME_C = 64'h0123456789ABCDEF;
  localparam logic [63:0] FRAME_D = 64'hF0E1D2C3B4A59687;
  localparam logic [63:0] FRAME_E = 64'h55AA55AA55AA55AA;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the first n cycles of one display period of frame f.
  task automatic push_frame(input logic [63:0] f, input bit done_first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   r;
      int   p;
      r = i / PER;
      p = i % PER;
      e = '0;
      if (p < DW) begin
        e.rs = 8'(1) << r;
        e.co = f[8*r +: 8];
        e.dn = done_first && (i == 0);
      end
      q.push_back(e);
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = (q.size() > 0) ? q.pop_front() : exp_t'(0);
    check(tag, {47'b0, row_sel, col_out, frame_done}, {47'b0, e});
  endtask

  initial begin
    // Reset and idle
    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs", {47'b0, row_sel, col_out, frame_done}, 64'd0);
    check("reset_ready", {63'b0, frame_ready}, 64'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick("idle_dark");
      check("idle_ready", {63'b0, frame_ready}, 64'd1);
    end

    // First frame: accepted at E0, swapped and shown from E1
    frame_in    = FRAME_A;
    frame_valid = 1'b1;
    tick("accept_a");
    check("ready_after_accept", {63'b0, frame_ready}, 64'd0);
    frame_valid = 1'b0;
    frame_in    = 64'hDEADBEEFCAFEF00D;
    push_frame(FRAME_A, 1'b0, FRAME_LEN);
    tick("swap_a");
    check("ready_after_swap", {63'b0, frame_ready}, 64'd1);
    for (int i = 1; i < 10; i++) tick("scan_a");

    // Double buffering: B accepted mid-scan, C held off until after the swap
    frame_in    = FRAME_B;
    frame_valid = 1'b1;
    tick("scan_a_accept_b");
    check("b_accepted", {63'b0, frame_ready}, 64'd0);
    push_frame(FRAME_B, 1'b1, FRAME_LEN);
    frame_in = FRAME_C;
    for (int i = 11; i < FRAME_LEN; i++) begin
      tick("scan_a_tail");
      check("c_blocked", {63'b0, frame_ready}, 64'd0);
    end
    tick("swap_b");
    check("ready_after_swap_b", {63'b0, frame_ready}, 64'd1);
    tick("scan_b_accept_c");
    check("c_accepted", {63'b0, frame_ready}, 64'd0);
    frame_valid = 1'b0;

    // C shown, then repeated unchanged, then cut during row 5
    for (int k = 0; k < 4; k++) push_frame(FRAME_C, 1'b1, FRAME_LEN);
    push_frame(FRAME_C, 1'b1, 5 * PER + 2);
    while (q.size() > 0) tick("scan_b_c_repeat");
    check("ready_idle_shadow", {63'b0, frame_ready}, 64'd1);

    // Disable: dark at once, no frame_done, handshake still live
    enable = 1'b0;
    for (int i = 0; i < 20; i++) tick("disabled_dark");
    check("disabled_ready", {63'b0, frame_ready}, 64'd1);
    frame_in    = FRAME_D;
    frame_valid = 1'b1;
    tick("disabled_accept_d");
    check("d_accepted_while_off", {63'b0, frame_ready}, 64'd0);
    frame_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick("disabled_pending");

    // Re-enable: pending D swapped in, row 0 with full dwell
    enable = 1'b1;
    push_frame(FRAME_D, 1'b0, FRAME_LEN);
    tick("reenable_swap_d");
    check("ready_after_swap_d", {63'b0, frame_ready}, 64'd1);
    for (int i = 0; i < 19; i++) tick("scan_d");
    frame_in    = FRAME_E;
    frame_valid = 1'b1;
    tick("scan_d_accept_e");
    check("e_accepted", {63'b0, frame_ready}, 64'd0);
    frame_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick("scan_d_more");

    // Asynchronous reset between edges discards pending E
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {47'b0, row_sel, col_out, frame_done}, 64'd0);
    check("async_reset_ready", {63'b0, frame_ready}, 64'd1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) tick("post_reset_dark");
    check("post_reset_ready", {63'b0, frame_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
